// File: rtl/pwm_io_pkg.sv
// rtl/pwm_io_pkg.sv - shared types for the PWM IO expander serial front end
package pwm_io_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } seqState_t;

  localparam logic [1:0] INC_HOLD   = 2'b00;
  localparam logic [1:0] INC_LINEAR = 2'b01;
  localparam logic [1:0] INC_BLOCK  = 2'b10;
  localparam logic [1:0] INC_RANGE  = 2'b11;

endpackage

// File: rtl/address_step_unit.sv
// rtl/address_step_unit.sv - next register pointer for the selected increment mode
module address_step_unit
  import pwm_io_pkg::*;
#(
  parameter int AddressWidth = 8,
  parameter logic [AddressWidth-1:0] MaxAddress = 'h1F,
  parameter int BlockLog2 = 2
) (
  input  logic [1:0]              mode,
  input  logic [AddressWidth-1:0] pointer,
  input  logic [AddressWidth-1:0] rangeBase,
  output logic [AddressWidth-1:0] nextPointer
);

  localparam logic [AddressWidth-1:0] BlockMask =
    {{(AddressWidth-BlockLog2){1'b0}}, {BlockLog2{1'b1}}};

  logic [AddressWidth-1:0] incremented;

  assign incremented = pointer + 1'b1;

  always_comb begin
    nextPointer = pointer;
    case (mode)
      INC_HOLD:   nextPointer = pointer;
      INC_LINEAR: nextPointer = incremented;
      // only the in-block bits move, so the pointer cycles within its block
      INC_BLOCK:  nextPointer = (pointer & ~BlockMask) | (incremented & BlockMask);
      INC_RANGE:  nextPointer = (pointer == MaxAddress) ? rangeBase : incremented;
      default:    nextPointer = pointer;
    endcase
  end

endmodule

// File: rtl/reg_address_sequencer.sv
// rtl/reg_address_sequencer.sv - register pointer and write strobe for the serial slave front end
module reg_address_sequencer
  import pwm_io_pkg::*;
#(
  parameter int AddressWidth = 8,
  parameter int DataWidth = 8,
  parameter logic [AddressWidth-1:0] MaxAddress = 'h1F,
  parameter int BlockLog2 = 2
) (
  input  logic                    CLK,
  input  logic                    _RST,
  input  logic                    StartStrobe,
  input  logic                    StopStrobe,
  input  logic                    IsRead,
  input  logic                    ByteStrobe,
  input  logic [DataWidth-1:0]    ByteIn,
  input  logic [1:0]              IncMode,
  output logic [AddressWidth-1:0] AddressBus,
  output logic                    WriteEnable,
  output logic                    TransferActive,
  output logic                    OutOfRange
);

  seqState_t               state, stateNext;
  logic [AddressWidth-1:0] pointer, pointerNext;
  logic [AddressWidth-1:0] rangeBase, rangeBaseNext;
  logic [AddressWidth-1:0] steppedPointer;
  logic [1:0]              modeLatched, modeNext;
  logic                    readLatched, readNext;

  address_step_unit #(
    .AddressWidth(AddressWidth),
    .MaxAddress  (MaxAddress),
    .BlockLog2   (BlockLog2)
  ) stepUnit (
    .mode       (modeLatched),
    .pointer    (pointer),
    .rangeBase  (rangeBase),
    .nextPointer(steppedPointer)
  );

  always_ff @(posedge CLK or negedge _RST) begin
    if (!_RST) begin
      state       <= ST_IDLE;
      pointer     <= '0;
      rangeBase   <= '0;
      modeLatched <= INC_LINEAR;
      readLatched <= 1'b0;
    end else begin
      state       <= stateNext;
      pointer     <= pointerNext;
      rangeBase   <= rangeBaseNext;
      modeLatched <= modeNext;
      readLatched <= readNext;
    end
  end

  always_comb begin
    stateNext     = state;
    pointerNext   = pointer;
    rangeBaseNext = rangeBase;
    modeNext      = modeLatched;
    readNext      = readLatched;
    WriteEnable   = 1'b0;
    if (StartStrobe) begin
      // a start overrides any byte or stop arriving in the same cycle
      modeNext  = IncMode;
      readNext  = IsRead;
      stateNext = IsRead ? ST_DATA : ST_ADDR;
    end else begin
      if (ByteStrobe) begin
        case (state)
          ST_ADDR: begin
            pointerNext   = ByteIn[AddressWidth-1:0];
            rangeBaseNext = ByteIn[AddressWidth-1:0];
            stateNext     = ST_DATA;
          end
          ST_DATA: begin
            WriteEnable = !readLatched && !OutOfRange;
            pointerNext = steppedPointer;
          end
          default: ;
        endcase
      end
      if (StopStrobe) stateNext = ST_IDLE;
    end
  end

  assign AddressBus     = pointer;
  assign TransferActive = (state != ST_IDLE);
  assign OutOfRange     = (pointer > MaxAddress);

endmodule

// File: tb/tb_reg_address_sequencer.sv
// tb/tb_reg_address_sequencer.sv - directed scoreboard bench for reg_address_sequencer
module tb_reg_address_sequencer;

  localparam logic [1:0] M_HOLD = 2'b00, M_LIN = 2'b01, M_BLK = 2'b10, M_RNG = 2'b11;

  logic       CLK = 1'b0;
  logic       _RST = 1'b0;
  logic       StartStrobe = 1'b0, StopStrobe = 1'b0, IsRead = 1'b0, ByteStrobe = 1'b0;
  logic [7:0] ByteIn = '0;
  logic [1:0] IncMode = M_LIN;
  logic [7:0] AddressBus;
  logic       WriteEnable, TransferActive, OutOfRange;

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
  } wr_t;

  wr_t expQ[$];
  int  vectors = 0;
  int  miscompares = 0;

  reg_address_sequencer dut (
    .CLK           (CLK),
    ._RST          (_RST),
    .StartStrobe   (StartStrobe),
    .StopStrobe    (StopStrobe),
    .IsRead        (IsRead),
    .ByteStrobe    (ByteStrobe),
    .ByteIn        (ByteIn),
    .IncMode       (IncMode),
    .AddressBus    (AddressBus),
    .WriteEnable   (WriteEnable),
    .TransferActive(TransferActive),
    .OutOfRange    (OutOfRange)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // every write seen by the bank must match the oldest expected write
  always @(negedge CLK) begin
    if (_RST && WriteEnable) begin
      vectors++;
      assert (expQ.size() != 0) else begin
        miscompares++;
        $error("FAIL unexpected_write observed addr=0x%0h data=0x%0h expected none", AddressBus, ByteIn);
      end
      if (expQ.size() != 0) begin
        wr_t e;
        e = expQ.pop_front();
        check("write_addr", AddressBus, e.addr);
        check("write_data", ByteIn, e.data);
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic startXfer(input logic rd, input logic [1:0] mode);
    StartStrobe = 1'b1; IsRead = rd; IncMode = mode;
    tick();
    StartStrobe = 1'b0;
  endtask

  task automatic stopXfer();
    StopStrobe = 1'b1;
    tick();
    StopStrobe = 1'b0;
  endtask

  task automatic sendByte(input logic [7:0] b, input logic expWrite, input logic [7:0] expAddr);
    if (expWrite) expQ.push_back('{addr: expAddr, data: b});
    ByteStrobe = 1'b1; ByteIn = b;
    tick();
    ByteStrobe = 1'b0;
  endtask

  initial begin
    #2;
    check("reset_addr", AddressBus, 8'h00);
    check("reset_active", TransferActive, 1'b0);
    check("reset_oor", OutOfRange, 1'b0);
    check("reset_we", WriteEnable, 1'b0);
    tick();
    _RST = 1'b1;
    tick();

    // LINEAR
    startXfer(1'b0, M_LIN);
    check("lin_active", TransferActive, 1'b1);
    sendByte(8'h05, 1'b0, 8'h00);
    check("lin_addr_latency", AddressBus, 8'h05);
    sendByte(8'hAA, 1'b1, 8'h05);
    sendByte(8'hBB, 1'b1, 8'h06);
    check("lin_ptr", AddressBus, 8'h07);
    stopXfer();
    check("lin_stop_idle", TransferActive, 1'b0);
    check("lin_stop_ptr", AddressBus, 8'h07);
    sendByte(8'h77, 1'b0, 8'h00);
    check("idle_byte_ignored", AddressBus, 8'h07);

    // LINEAR wrap from the top of the address space (beyond the map, so no write)
    startXfer(1'b0, M_LIN);
    sendByte(8'hFF, 1'b0, 8'h00);
    check("wrap_oor", OutOfRange, 1'b1);
    sendByte(8'h11, 1'b0, 8'h00);
    check("wrap_ptr", AddressBus, 8'h00);
    check("wrap_oor_clear", OutOfRange, 1'b0);
    stopXfer();

    // BLOCK
    startXfer(1'b0, M_BLK);
    sendByte(8'h0E, 1'b0, 8'h00);
    sendByte(8'h01, 1'b1, 8'h0E);
    sendByte(8'h02, 1'b1, 8'h0F);
    sendByte(8'h03, 1'b1, 8'h0C);
    check("blk_ptr", AddressBus, 8'h0D);
    stopXfer();

    // RANGE
    startXfer(1'b0, M_RNG);
    sendByte(8'h1E, 1'b0, 8'h00);
    sendByte(8'hC1, 1'b1, 8'h1E);
    sendByte(8'hC2, 1'b1, 8'h1F);
    sendByte(8'hC3, 1'b1, 8'h1E);
    sendByte(8'hC4, 1'b1, 8'h1F);
    check("rng_ptr", AddressBus, 8'h1E);
    stopXfer();

    // Out of range
    startXfer(1'b0, M_LIN);
    sendByte(8'h30, 1'b0, 8'h00);
    check("oor_flag", OutOfRange, 1'b1);
    ByteStrobe = 1'b1; ByteIn = 8'h44;
    #1;
    check("oor_we_suppressed", WriteEnable, 1'b0);
    tick();
    ByteStrobe = 1'b0;
    check("oor_ptr", AddressBus, 8'h31);
    stopXfer();

    // Read resume; IncMode changed mid-transfer must not matter
    startXfer(1'b0, M_LIN);
    sendByte(8'h10, 1'b0, 8'h00);
    stopXfer();
    startXfer(1'b1, M_LIN);
    IncMode = M_HOLD;
    check("rd_resume_ptr", AddressBus, 8'h10);
    check("rd_active", TransferActive, 1'b1);
    sendByte(8'h99, 1'b0, 8'h00);
    sendByte(8'h98, 1'b0, 8'h00);
    check("rd_ptr", AddressBus, 8'h12);
    stopXfer();

    // Collisions
    startXfer(1'b0, M_LIN);
    sendByte(8'h08, 1'b0, 8'h00);
    StartStrobe = 1'b1; IsRead = 1'b0; IncMode = M_LIN; ByteStrobe = 1'b1; ByteIn = 8'h55;
    #1;
    check("start_byte_no_we", WriteEnable, 1'b0);
    tick();
    StartStrobe = 1'b0; ByteStrobe = 1'b0;
    check("start_byte_ptr", AddressBus, 8'h08);
    sendByte(8'h09, 1'b0, 8'h00);
    check("start_byte_readdr", AddressBus, 8'h09);
    expQ.push_back('{addr: 8'h09, data: 8'h66});
    StopStrobe = 1'b1; ByteStrobe = 1'b1; ByteIn = 8'h66;
    tick();
    StopStrobe = 1'b0; ByteStrobe = 1'b0;
    check("stop_byte_idle", TransferActive, 1'b0);
    check("stop_byte_ptr", AddressBus, 8'h0A);
    StartStrobe = 1'b1; StopStrobe = 1'b1; IsRead = 1'b0;
    tick();
    StartStrobe = 1'b0; StopStrobe = 1'b0;
    check("start_stop_active", TransferActive, 1'b1);

    // Reset mid-DATA
    sendByte(8'h03, 1'b0, 8'h00);
    sendByte(8'h5A, 1'b1, 8'h03);
    #2;
    _RST = 1'b0;
    ByteStrobe = 1'b1; ByteIn = 8'hEE;
    #1;
    check("rst_addr", AddressBus, 8'h00);
    check("rst_active", TransferActive, 1'b0);
    check("rst_we", WriteEnable, 1'b0);
    tick();
    ByteStrobe = 1'b0;
    _RST = 1'b1;
    tick();
    check("rst_after_addr", AddressBus, 8'h00);

    tick();
    check("scoreboard_empty", expQ.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
